pwm_deadtime: RTL
=================

# pwm_deadtime

Dead-time and complementary-output generator that sits directly downstream of the six-channel PWM block. It converts each single-ended `pwm_wfm` bit into a non-overlapping high-side/low-side pair with programmable rising and falling dead-time. It also provides a latched, synchronised fault input that forces every output to the safe (all-off) state. Registers are reached through the same 32-bit register bus used by the PWM block.

## Interface
Parameters:
- `NCH`, 6: number of channels; must match the `pwm_wfm` width.
- `DTW`, 8: dead-time counter width.

Ports:
- `mclk`  in  1  system clock
- `h_reset_n`  in  1  asynchronous, active-low reset
- `reg_cs`  in  1  register chip select; held high until `reg_ack`
- `reg_wr`  in  1  1 = write, 0 = read
- `reg_addr`  in  2  word address
- `reg_wdata`  in  32  write data
- `reg_be`  in  4  byte enables, write only
- `reg_rdata`  out  32  read data, valid with `reg_ack`
- `reg_ack`  out  1  one-cycle access acknowledge
- `pwm_wfm`  in  NCH  raw PWM waveforms, `mclk`-synchronous
- `fault_in`  in  1  asynchronous external fault pin
- `pwm_hs`  out  NCH  high-side drive
- `pwm_ls`  out  NCH  low-side drive
- `fault_intr`  out  1  level interrupt; equals `fault_lat & fault_en`

## Operation
Register map:
- addr 0, CTRL (rw):
  - [5:0] `ch_en`
  - [8] `fault_en`
  - [9] `fault_pol` (1 = active high)
- addr 1, DT (rw):
  - [7:0] `dt_r`: low-side-off to high-side-on gap, in cycles
  - [15:8] `dt_f`: high-side-off to low-side-on gap, in cycles
- addr 2, STATUS:
  - [5:0] `pwm_hs` (ro)
  - [13:8] `pwm_ls` (ro)
  - [16] `fault_lat` (write 1 to clear)
- addr 3: reads 0; writes ignored.
- All unused bits read 0. Reset value of every register field is 0.

Bus access:
- An access is accepted on a cycle with `reg_cs & !reg_ack`.
- A write updates the enabled bytes on that cycle.
- `reg_ack` and `reg_rdata` are registered. Both are valid in the following cycle, for one cycle only.

Per-channel datapath:
- `pwm_wfm` is registered once to give `wfm_q`.
- Each channel runs a four-state FSM: LS_ON, DT_RISE, HS_ON, DT_FALL.
- Outputs by state:
  - LS_ON: `ls=1`, `hs=0`
  - HS_ON: `hs=1`, `ls=0`
  - DT_RISE and DT_FALL: both 0
- Outputs are registered, decoded from the next state.

Transitions:
- LS_ON, `wfm_q=1`: go to DT_RISE with `cnt=dt_r`, or straight to HS_ON if `dt_r==0`.
- DT_RISE: decrement `cnt`; go to HS_ON when `cnt==1`.
  - If `wfm_q=0` while in DT_RISE, return to LS_ON immediately (abort).
- HS_ON, `wfm_q=0`: go to DT_FALL with `cnt=dt_f`, or straight to LS_ON if `dt_f==0`.
- DT_FALL: mirror of DT_RISE; `wfm_q=1` returns to HS_ON immediately.
- `hs` and `ls` are never 1 together in any state, including on an abort path.
- A DT write takes effect at the next counter load; a count already in progress is unaffected.

Channel disable:
- With `ch_en[i]=0`, the FSM is held in LS_ON, `cnt=0`, and `hs=ls=0`.
- On enable, the channel starts from LS_ON: `ls=1` the next cycle if `wfm_q=0`, otherwise it enters DT_RISE.

Fault handling:
- `fault_in` passes through a 2-flop synchroniser to give `flt_s`.
- `fault_lat` sets when `fault_en & (flt_s==fault_pol)`.
- While `fault_lat=1`, all FSMs are forced to LS_ON with every output 0.
- A write-1-to-clear succeeds only if the fault condition is inactive in that cycle. Otherwise `fault_lat` stays 1.
- If set and clear occur in the same cycle, set wins.

## Timing
- Reset: all FSMs in LS_ON, `cnt=0`, `pwm_hs=0`, `pwm_ls=0`, `fault_intr=0`, `reg_ack=0`, `reg_rdata=0`, synchroniser flops 0.
- Edge latency, `pwm_wfm` rising at cycle t:
  - `wfm_q` at t+1
  - `ls` falls at t+2
  - `hs` rises at t+2+`dt_r` (at t+2 when `dt_r=0`)
- Falling edge is symmetric using `dt_f`.
- A pulse shorter than `dt_r` never produces `hs`.
- Fault latency: `fault_in` asserting at t gives `fault_lat` at t+3 and outputs 0 at t+4.
- Reset asserted mid-dead-time: outputs go to 0 asynchronously.
- Register ack: one cycle after the accepting cycle; back-to-back accesses run at one per 2 cycles.

## Test plan
- `dt_r=3`, `dt_f=5`, `ch_en=0x01`, `pwm_wfm[0]` 0→1 at t, back to 0 at t+20:
  - `ls0` falls at t+2, `hs0` rises at t+5
  - `hs0` falls at t+22, `ls0` rises at t+27
  - `hs0&ls0` never 1
- `dt_r=8`, 4-cycle pulse on `pwm_wfm[2]`: `hs2` stays 0; `ls2` off for exactly 4 cycles.
- `dt_r=dt_f=0`, 50% toggling on all six channels: `hs=wfm` delayed 2 cycles; `ls` is its complement.
- `fault_en=1`, `fault_pol=1`, pulse `fault_in` high:
  - outputs go to 0, `fault_intr=1`
  - W1C issued while the pin is still high: `fault_lat` stays 1
  - W1C issued after the pin drops: cleared, normal operation resumes from LS_ON
- Register access:
  - write DT=0x0000_1234 with `be=4'b0001`: reads back 0x0000_0034
  - read addr 3 returns 0
  - `reg_ack` is exactly one cycle
- Assert `h_reset_n` during DT_RISE: outputs 0 immediately; all registers read 0 after release.

Source files
------------

// File: rtl/pwm_deadtime_if.sv
// pwm_deadtime_if -- 32-bit register bus shared with the six-channel PWM block.
//
// Signals:
//   reg_cs     master->slave  chip select, held high until reg_ack
//   reg_wr     master->slave  1 = write, 0 = read
//   reg_addr   master->slave  word address
//   reg_wdata  master->slave  write data
//   reg_be     master->slave  byte enables (writes only)
//   reg_rdata  slave->master  read data, valid together with reg_ack
//   reg_ack    slave->master  one-cycle access acknowledge
interface pwm_deadtime_if;
  logic        reg_cs;
  logic        reg_wr;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ack;

  modport master (
    output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    input  reg_rdata, reg_ack
  );

  modport slave (
    input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    output reg_rdata, reg_ack
  );
endinterface

// File: rtl/pwm_deadtime.sv
// pwm_deadtime -- dead-time and complementary-output generator.
//
// Turns every single-ended pwm_wfm bit into a non-overlapping high-side /
// low-side pair with programmable rising (dt_r) and falling (dt_f) gaps, and
// forces all outputs off while a latched, synchronised fault is pending.
//
// Ports:
//   mclk        system clock
//   h_reset_n   asynchronous, active-low reset
//   bus         register bus (slave side): CTRL @0, DT @1, STATUS @2, addr 3 reads 0
//   pwm_wfm     raw PWM waveforms, mclk-synchronous
//   fault_in    asynchronous external fault pin
//   pwm_hs      high-side drive, one bit per channel
//   pwm_ls      low-side drive, one bit per channel
//   fault_intr  level interrupt = fault_lat & fault_en
//
// The register map packs ch_en/hs/ls into 6-bit fields and dt_r/dt_f into
// bytes, so NCH <= 8 and DTW <= 8 keep the fields from overlapping.
module pwm_deadtime #(
  parameter int NCH = 6,
  parameter int DTW = 8
) (
  input  logic           mclk,
  input  logic           h_reset_n,
  pwm_deadtime_if.slave  bus,
  input  logic [NCH-1:0] pwm_wfm,
  input  logic           fault_in,
  output logic [NCH-1:0] pwm_hs,
  output logic [NCH-1:0] pwm_ls,
  output logic           fault_intr
);

  typedef enum logic [1:0] {
    LS_ON   = 2'd0,
    DT_RISE = 2'd1,
    HS_ON   = 2'd2,
    DT_FALL = 2'd3
  } ch_state_e;

  localparam logic [DTW-1:0] CNT_ONE = DTW'(1);

  logic [NCH-1:0] ch_en_q;
  logic           fault_en_q;
  logic           fault_pol_q;
  logic [DTW-1:0] dt_r_q;
  logic [DTW-1:0] dt_f_q;
  logic           fault_lat_q;
  logic           fault_lat_d;
  logic           flt_meta_q;
  logic           flt_s_q;
  logic           ack_q;
  logic [31:0]    rdata_q;
  logic [31:0]    rdata_d;
  logic [NCH-1:0] wfm_q;

  logic acc;
  logic wr_acc;
  logic flt_cond;
  logic flt_clr;

  // An access is taken only while ack is low, so a held chip select yields
  // one access every two cycles.
  assign acc      = bus.reg_cs & ~ack_q;
  assign wr_acc   = acc & bus.reg_wr;
  assign flt_cond = fault_en_q & (flt_s_q == fault_pol_q);
  assign flt_clr  = wr_acc & (bus.reg_addr == 2'd2) & bus.reg_be[2] & bus.reg_wdata[16];

  // Set has priority: a clear while the fault condition is still active is lost.
  always_comb begin
    fault_lat_d = fault_lat_q;
    if (flt_cond) begin
      fault_lat_d = 1'b1;
    end else if (flt_clr) begin
      fault_lat_d = 1'b0;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (acc && !bus.reg_wr) begin
      case (bus.reg_addr)
        2'd0: begin
          rdata_d[NCH-1:0] = ch_en_q;
          rdata_d[8]       = fault_en_q;
          rdata_d[9]       = fault_pol_q;
        end
        2'd1: begin
          rdata_d[DTW-1:0] = dt_r_q;
          rdata_d[8 +: DTW] = dt_f_q;
        end
        2'd2: begin
          rdata_d[NCH-1:0] = pwm_hs;
          rdata_d[8 +: NCH] = pwm_ls;
          rdata_d[16]      = fault_lat_q;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      ch_en_q     <= '0;
      fault_en_q  <= 1'b0;
      fault_pol_q <= 1'b0;
      dt_r_q      <= '0;
      dt_f_q      <= '0;
      fault_lat_q <= 1'b0;
      flt_meta_q  <= 1'b0;
      flt_s_q     <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      wfm_q       <= '0;
    end else begin
      flt_meta_q  <= fault_in;
      flt_s_q     <= flt_meta_q;
      fault_lat_q <= fault_lat_d;
      ack_q       <= acc;
      rdata_q     <= rdata_d;
      wfm_q       <= pwm_wfm;
      if (wr_acc && bus.reg_addr == 2'd0) begin
        if (bus.reg_be[0]) ch_en_q <= bus.reg_wdata[NCH-1:0];
        if (bus.reg_be[1]) begin
          fault_en_q  <= bus.reg_wdata[8];
          fault_pol_q <= bus.reg_wdata[9];
        end
      end
      if (wr_acc && bus.reg_addr == 2'd1) begin
        if (bus.reg_be[0]) dt_r_q <= bus.reg_wdata[DTW-1:0];
        if (bus.reg_be[1]) dt_f_q <= bus.reg_wdata[8 +: DTW];
      end
    end
  end

  assign bus.reg_ack   = ack_q;
  assign bus.reg_rdata = rdata_q;
  assign fault_intr    = fault_lat_q & fault_en_q;

  // One dead-time FSM per channel.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    ch_state_e      st_q, st_d;
    logic [DTW-1:0] cnt_q, cnt_d;
    logic           hs_q, ls_q, hs_d, ls_d;
    logic           hold;

    assign hold = ~ch_en_q[gi] | fault_lat_q;

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      if (hold) begin
        st_d  = LS_ON;
        cnt_d = '0;
      end else begin
        case (st_q)
          LS_ON: begin
            if (wfm_q[gi]) begin
              if (dt_r_q == '0) begin
                st_d = HS_ON;
              end else begin
                st_d  = DT_RISE;
                cnt_d = dt_r_q;
              end
            end
          end
          DT_RISE: begin
            if (!wfm_q[gi]) begin
              st_d  = LS_ON;
              cnt_d = '0;
            end else if (cnt_q == CNT_ONE) begin
              st_d  = HS_ON;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          HS_ON: begin
            if (!wfm_q[gi]) begin
              if (dt_f_q == '0) begin
                st_d = LS_ON;
              end else begin
                st_d  = DT_FALL;
                cnt_d = dt_f_q;
              end
            end
          end
          DT_FALL: begin
            if (wfm_q[gi]) begin
              st_d  = HS_ON;
              cnt_d = '0;
            end else if (cnt_q == CNT_ONE) begin
              st_d  = LS_ON;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          default: begin
            st_d  = LS_ON;
            cnt_d = '0;
          end
        endcase
      end
      // Decoding from the next state keeps hs and ls mutually exclusive on
      // every path, aborts included; a held channel drives neither side.
      hs_d = ~hold & (st_d == HS_ON);
      ls_d = ~hold & (st_d == LS_ON);
    end

    always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
        st_q  <= LS_ON;
        cnt_q <= '0;
        hs_q  <= 1'b0;
        ls_q  <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        hs_q  <= hs_d;
        ls_q  <= ls_d;
      end
    end

    assign pwm_hs[gi] = hs_q;
    assign pwm_ls[gi] = ls_q;
  end

endmodule
